zeroriscy_hpm_counters: RTL and testbench
=========================================

ZERORISCY_HPM_COUNTERS -- requirements
Module: zeroriscy_hpm_counters

Interface
REQ-001 SHALL have parameter N_COUNTERS, default 4, number of programmable counters (legal range 1..16).
REQ-002 SHALL have parameter N_EVENTS, default 16, number of event inputs (legal range 1..32).
REQ-003 SHALL have parameter CNT_WIDTH, default 64, counter width (legal range 33..64; 64 at default).
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 csr_access_i  in  1  CSR access valid this cycle.
REQ-007 csr_addr_i  in  12  CSR address.
REQ-008 csr_wdata_i  in  32  CSR write operand.
REQ-009 csr_op_i  in  2  CSR_OP_NONE/WRITE/SET/CLEAR.
REQ-010 csr_rdata_o  out  32  read data, combinational from current state.
REQ-011 csr_hit_o  out  1  address decodes to a register of this block (qualified by csr_access_i).
REQ-012 events_i  in  N_EVENTS  single-cycle event pulses, one bit per event.
REQ-013 ovf_irq_o  out  1  overflow interrupt request, registered.

Function
REQ-014 Address map: 0x7C0+i event select (i<N_COUNTERS, 5 bits); 0xB00+i counter low 32 bits; 0xB80+i counter high CNT_WIDTH-32 bits, zero-extended on read; 0x320 inhibit (N_COUNTERS bits); 0x7E0 overflow status (sticky); 0x7E1 overflow interrupt enable.
REQ-015 Unmapped addresses or counter index >= N_COUNTERS SHALL give csr_hit_o=0 and csr_rdata_o=0, with no state change.
REQ-016 Writes SHALL take effect only when csr_access_i=1 and csr_hit_o=1; WRITE: q=wdata, SET: q=q|wdata, CLEAR: q=q&~wdata, NONE: no change; unused high bits SHALL be ignored.
REQ-017 Event select values >= N_EVENTS SHALL select no event (counter idles).
REQ-018 Selected event bit ANDed with ~inhibit[i] SHALL be registered into inc_q[i]; counter i SHALL increment by 1 in the cycle after inc_q[i]=1 (total event-to-count latency 2 edges).
REQ-019 A CSR write to either half of counter i SHALL override any increment of counter i in that cycle; the other half SHALL retain its value.
REQ-020 Increment from all-ones SHALL set ovf_q[i] in the same edge (behaviour of the counter value per REQ-027).
REQ-021 Overflow status bits SHALL be cleared only via CSR write/clear to 0x7E0; a simultaneous overflow event and software clear of the same bit SHALL leave the bit set.
REQ-022 ovf_irq_o SHALL equal the registered value of |(ovf_q & ovf_ie_q), asserting 1 cycle after the bit is set.
REQ-023 Changing an event select or inhibit bit SHALL not affect an already-registered inc_q pulse.

Reset
REQ-024 On rst_n=0, all counters, ovf_q, ovf_ie_q, inc_q and ovf_irq_o SHALL reset to 0.
REQ-025 On rst_n=0, inhibit SHALL reset to all-ones (all counters stopped) and event selects to 0.
REQ-026 Reset asserted mid-count SHALL discard pending inc_q pulses; first count after release requires a fresh event.

Configuration
REQ-027 Macro HPM_SATURATE_EN: when defined, counters SHALL hold at all-ones instead of incrementing further (ovf_q still set); when undefined, counters SHALL wrap to 0.

Structure
REQ-028 Address constants, CNT_WIDTH limits and the CSR_OP encoding SHALL live in zeroriscy_defines.
REQ-029 One sub-module zeroriscy_hpm_counter (single counter: inc register, low/high write, overflow detect) SHALL be instantiated N_COUNTERS times by generate loop.

Verification
REQ-030 Reset, set event select 0x7C0=2, clear inhibit bit 0, pulse events_i[2] 3 times -> read 0xB00 = 3, 0xB80 = 0.
REQ-031 Write 0xB00=0xFFFFFFFF, 0xB80=0xFFFFFFFF, ie=1, one event -> wrap: counter 0, 0x7E0 bit0=1, ovf_irq_o=1 one cycle later; with HPM_SATURATE_EN the counter stays all-ones.
REQ-032 Write 0xB00=0x1234 in the same cycle inc_q[0]=1 -> read 0x1234, not 0x1235.
REQ-033 CLEAR op on 0x7E0 with wdata=1 coincident with new overflow -> bit stays 1; next CLEAR alone -> 0, ovf_irq_o deasserts one cycle later.
REQ-034 Event select 0x7C0=31 with N_EVENTS=16 and all events pulsing -> counter stays 0; read 0xB0F with N_COUNTERS=4 -> csr_hit_o=0, data 0.
REQ-035 Assert rst_n during counting with inhibit cleared -> all counters 0, inhibit 0xF after release.

Source files
------------

// File: rtl/zeroriscy_defines.sv
// -----------------------------------------------------------------------------
// zeroriscy_defines
// Shared definitions for the hardware performance monitor (HPM) counter block:
//   - CSR address constants for the HPM register map
//   - legal counter-width limits
//   - CSR operation encoding (csr_op_e) and a helper that applies an op to a
//     register value
// No ports (package).
// -----------------------------------------------------------------------------
package zeroriscy_defines;

  // HPM CSR address map
  localparam logic [11:0] CSR_HPM_EVTSEL_BASE = 12'h7C0;
  localparam logic [11:0] CSR_HPM_CNT_LO_BASE = 12'hB00;
  localparam logic [11:0] CSR_HPM_CNT_HI_BASE = 12'hB80;
  localparam logic [11:0] CSR_HPM_INHIBIT     = 12'h320;
  localparam logic [11:0] CSR_HPM_OVF_STATUS  = 12'h7E0;
  localparam logic [11:0] CSR_HPM_OVF_IE      = 12'h7E1;

  // Counter width limits
  localparam int unsigned HPM_CNT_WIDTH_MIN = 33;
  localparam int unsigned HPM_CNT_WIDTH_MAX = 64;

  // Event-select field width
  localparam int unsigned HPM_EVTSEL_WIDTH = 5;

  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  // Returns the new register value after applying a CSR op to q
  function automatic logic [31:0] csr_apply_op(csr_op_e op, logic [31:0] q,
                                               logic [31:0] wdata);
    logic [31:0] res;
    unique case (op)
      CSR_OP_WRITE: res = wdata;
      CSR_OP_SET:   res = q | wdata;
      CSR_OP_CLEAR: res = q & ~wdata;
      default:      res = q;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/zeroriscy_hpm_counter.sv
// -----------------------------------------------------------------------------
// zeroriscy_hpm_counter
// One programmable HPM counter: registers the gated event into an increment
// pulse, applies CSR writes to the low/high halves, and flags overflow when an
// increment happens from all-ones.
// Build option: define HPM_SATURATE_EN to hold at all-ones instead of wrapping.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_event      selected and uninhibited event bit for this counter
//   i_wr_lo      CSR write to counter bits [31:0] this cycle
//   i_wr_hi      CSR write to counter bits [CNT_WIDTH-1:32] this cycle
//   i_op         CSR operation (csr_op_e encoding)
//   i_wdata      CSR write operand
//   o_cnt        current counter value
//   o_ovf        overflow pulse, valid in the cycle the wrapping edge occurs
// -----------------------------------------------------------------------------
module zeroriscy_hpm_counter
  import zeroriscy_defines::*;
#(
  parameter int unsigned CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_event,
  input  logic                 i_wr_lo,
  input  logic                 i_wr_hi,
  input  logic [1:0]           i_op,
  input  logic [31:0]          i_wdata,
  output logic [CNT_WIDTH-1:0] o_cnt,
  output logic                 o_ovf
);

  localparam int unsigned HI_W = CNT_WIDTH - 32;

  logic                 r_inc;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_d;
  logic [31:0]          w_hi_zext;
  logic [31:0]          w_lo_new;
  logic [31:0]          w_hi_new;
  logic                 w_all_ones;
  logic                 w_ovf;
  csr_op_e              w_op;

  assign w_op       = csr_op_e'(i_op);
  assign w_all_ones = &r_cnt;
  assign w_lo_new   = csr_apply_op(w_op, r_cnt[31:0], i_wdata);
  assign w_hi_new   = csr_apply_op(w_op, w_hi_zext, i_wdata);

  always_comb begin
    w_hi_zext = '0;
    w_hi_zext[HI_W-1:0] = r_cnt[CNT_WIDTH-1:32];
  end

  // A write to either half wins over a pending increment; the untouched half keeps its value
  always_comb begin
    w_cnt_d = r_cnt;
    w_ovf   = 1'b0;
    if (i_wr_lo || i_wr_hi) begin
      if (i_wr_lo) w_cnt_d[31:0] = w_lo_new;
      if (i_wr_hi) w_cnt_d[CNT_WIDTH-1:32] = w_hi_new[HI_W-1:0];
    end else if (r_inc) begin
      w_ovf = w_all_ones;
`ifdef HPM_SATURATE_EN
      if (!w_all_ones) w_cnt_d = r_cnt + CNT_WIDTH'(1);
`else
      w_cnt_d = r_cnt + CNT_WIDTH'(1);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inc <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_inc <= i_event;
      r_cnt <= w_cnt_d;
    end
  end

  assign o_cnt = r_cnt;
  assign o_ovf = w_ovf;

endmodule

// File: rtl/zeroriscy_hpm_counters.sv
// -----------------------------------------------------------------------------
// zeroriscy_hpm_counters
// Bank of N_COUNTERS programmable performance counters with CSR access,
// per-counter event select, inhibit mask, sticky overflow status and a
// registered overflow interrupt.
// Build option: HPM_SATURATE_EN (see zeroriscy_hpm_counter) - counters saturate.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   csr_access_i  CSR access valid this cycle
//   csr_addr_i    CSR address
//   csr_wdata_i   CSR write operand
//   csr_op_i      CSR op (NONE/WRITE/SET/CLEAR)
//   csr_rdata_o   combinational read data (0 when not hit)
//   csr_hit_o     access decodes to a register of this block
//   events_i      single-cycle event pulses
//   ovf_irq_o     registered overflow interrupt request
// -----------------------------------------------------------------------------
module zeroriscy_hpm_counters
  import zeroriscy_defines::*;
#(
  parameter int unsigned N_COUNTERS = 4,
  parameter int unsigned N_EVENTS   = 16,
  parameter int unsigned CNT_WIDTH  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                csr_access_i,
  input  logic [11:0]         csr_addr_i,
  input  logic [31:0]         csr_wdata_i,
  input  logic [1:0]          csr_op_i,
  output logic [31:0]         csr_rdata_o,
  output logic                csr_hit_o,
  input  logic [N_EVENTS-1:0] events_i,
  output logic                ovf_irq_o
);

  logic [HPM_EVTSEL_WIDTH-1:0] r_evtsel [N_COUNTERS];
  logic [HPM_EVTSEL_WIDTH-1:0] w_evtsel_d [N_COUNTERS];
  logic [N_COUNTERS-1:0]       r_inhibit, w_inhibit_d;
  logic [N_COUNTERS-1:0]       r_ovf, w_ovf_d;
  logic [N_COUNTERS-1:0]       r_ovf_ie, w_ovf_ie_d;
  logic                        r_irq;

  logic [CNT_WIDTH-1:0]        w_cnt [N_COUNTERS];
  logic [N_COUNTERS-1:0]       w_ovf_set;
  logic [N_COUNTERS-1:0]       w_evt;
  logic [N_COUNTERS-1:0]       w_wr_lo;
  logic [N_COUNTERS-1:0]       w_wr_hi;
  logic [31:0]                 w_ev_pad;

  logic [3:0] w_idx;
  logic       w_idx_ok;
  logic       w_sel_evtsel, w_sel_lo, w_sel_hi;
  logic       w_sel_inhibit, w_sel_ovf, w_sel_ie;
  logic       w_wr;
  csr_op_e    w_op;

  // Address decode
  assign w_idx         = csr_addr_i[3:0];
  assign w_idx_ok      = ({28'd0, w_idx} < N_COUNTERS);
  assign w_sel_evtsel  = (csr_addr_i[11:4] == CSR_HPM_EVTSEL_BASE[11:4]) && w_idx_ok;
  assign w_sel_lo      = (csr_addr_i[11:4] == CSR_HPM_CNT_LO_BASE[11:4]) && w_idx_ok;
  assign w_sel_hi      = (csr_addr_i[11:4] == CSR_HPM_CNT_HI_BASE[11:4]) && w_idx_ok;
  assign w_sel_inhibit = (csr_addr_i == CSR_HPM_INHIBIT);
  assign w_sel_ovf     = (csr_addr_i == CSR_HPM_OVF_STATUS);
  assign w_sel_ie      = (csr_addr_i == CSR_HPM_OVF_IE);

  assign csr_hit_o = csr_access_i && (w_sel_evtsel || w_sel_lo || w_sel_hi ||
                                      w_sel_inhibit || w_sel_ovf || w_sel_ie);
  assign w_op      = csr_op_e'(csr_op_i);
  assign w_wr      = csr_hit_o && (w_op != CSR_OP_NONE);

  // Zero-padded event vector: selects >= N_EVENTS land on a constant 0
  always_comb begin
    w_ev_pad = '0;
    for (int unsigned i = 0; i < N_EVENTS; i++) w_ev_pad[i] = events_i[i];
  end

  for (genvar g = 0; g < N_COUNTERS; g++) begin : gen_cnt
    assign w_evt[g]   = w_ev_pad[r_evtsel[g]] & ~r_inhibit[g];
    assign w_wr_lo[g] = w_wr && w_sel_lo && (w_idx == 4'(g));
    assign w_wr_hi[g] = w_wr && w_sel_hi && (w_idx == 4'(g));

    zeroriscy_hpm_counter #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_event (w_evt[g]),
      .i_wr_lo (w_wr_lo[g]),
      .i_wr_hi (w_wr_hi[g]),
      .i_op    (csr_op_i),
      .i_wdata (csr_wdata_i),
      .o_cnt   (w_cnt[g]),
      .o_ovf   (w_ovf_set[g])
    );
  end

  // Control register next state
  always_comb begin
    w_inhibit_d = r_inhibit;
    w_ovf_d     = r_ovf;
    w_ovf_ie_d  = r_ovf_ie;
    for (int unsigned i = 0; i < N_COUNTERS; i++) begin
      w_evtsel_d[i] = r_evtsel[i];
      if (w_wr && w_sel_evtsel && (w_idx == 4'(i))) begin
        w_evtsel_d[i] = HPM_EVTSEL_WIDTH'(csr_apply_op(w_op, 32'(r_evtsel[i]), csr_wdata_i));
      end
    end
    if (w_wr && w_sel_inhibit) begin
      w_inhibit_d = N_COUNTERS'(csr_apply_op(w_op, 32'(r_inhibit), csr_wdata_i));
    end
    if (w_wr && w_sel_ie) begin
      w_ovf_ie_d = N_COUNTERS'(csr_apply_op(w_op, 32'(r_ovf_ie), csr_wdata_i));
    end
    if (w_wr && w_sel_ovf) begin
      w_ovf_d = N_COUNTERS'(csr_apply_op(w_op, 32'(r_ovf), csr_wdata_i));
    end
    // A hardware overflow beats a simultaneous software clear
    w_ovf_d = w_ovf_d | w_ovf_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_COUNTERS; i++) r_evtsel[i] <= '0;
      r_inhibit <= '1;
      r_ovf     <= '0;
      r_ovf_ie  <= '0;
      r_irq     <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N_COUNTERS; i++) r_evtsel[i] <= w_evtsel_d[i];
      r_inhibit <= w_inhibit_d;
      r_ovf     <= w_ovf_d;
      r_ovf_ie  <= w_ovf_ie_d;
      r_irq     <= |(r_ovf & r_ovf_ie);
    end
  end

  assign ovf_irq_o = r_irq;

  // Read mux
  always_comb begin
    csr_rdata_o = '0;
    if (csr_hit_o) begin
      if (w_sel_inhibit) csr_rdata_o = 32'(r_inhibit);
      if (w_sel_ovf)     csr_rdata_o = 32'(r_ovf);
      if (w_sel_ie)      csr_rdata_o = 32'(r_ovf_ie);
      for (int unsigned i = 0; i < N_COUNTERS; i++) begin
        if (w_idx == 4'(i)) begin
          if (w_sel_evtsel) csr_rdata_o = 32'(r_evtsel[i]);
          if (w_sel_lo)     csr_rdata_o = w_cnt[i][31:0];
          if (w_sel_hi)     csr_rdata_o[CNT_WIDTH-33:0] = w_cnt[i][CNT_WIDTH-1:32];
        end
      end
    end
  end

endmodule

// File: tb/tb_zeroriscy_hpm_counters.sv
// -----------------------------------------------------------------------------
// tb_zeroriscy_hpm_counters
// Self-checking bench: directed scenarios plus randomized CSR traffic and
// events, compared every cycle against a behavioural model of the counter bank.
// -----------------------------------------------------------------------------
module tb_zeroriscy_hpm_counters;

  localparam int unsigned NC = 4;
  localparam int unsigned NE = 16;
  localparam int unsigned CW = 64;
  localparam longint unsigned CNT_MAX = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam longint unsigned HI_MASK = CNT_MAX >> 32;
  localparam longint unsigned LO_MASK = 64'hFFFF_FFFF;

  localparam bit [1:0] OP_NONE  = 2'd0;
  localparam bit [1:0] OP_WRITE = 2'd1;
  localparam bit [1:0] OP_SET   = 2'd2;
  localparam bit [1:0] OP_CLEAR = 2'd3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          csr_access_i;
  logic [11:0]   csr_addr_i;
  logic [31:0]   csr_wdata_i;
  logic [1:0]    csr_op_i;
  logic [31:0]   csr_rdata_o;
  logic          csr_hit_o;
  logic [NE-1:0] events_i;
  logic          ovf_irq_o;

  always #5 clk = ~clk;

  zeroriscy_hpm_counters #(
    .N_COUNTERS (NC),
    .N_EVENTS   (NE),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .csr_access_i (csr_access_i),
    .csr_addr_i   (csr_addr_i),
    .csr_wdata_i  (csr_wdata_i),
    .csr_op_i     (csr_op_i),
    .csr_rdata_o  (csr_rdata_o),
    .csr_hit_o    (csr_hit_o),
    .events_i     (events_i),
    .ovf_irq_o    (ovf_irq_o)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- behavioural model ----------------
  longint unsigned m_cnt [NC];
  int unsigned     m_sel [NC];
  bit              m_inc [NC];   // event seen last cycle, counts this cycle
  bit [NC-1:0]     m_inh, m_ovf, m_ie;
  bit              m_irq;

  function automatic longint unsigned apply(bit [1:0] op, longint unsigned q, longint unsigned w);
    case (op)
      OP_WRITE: return w;
      OP_SET:   return q | w;
      OP_CLEAR: return q & ~w;
      default:  return q;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NC; i++) begin
      m_cnt[i] = 0;
      m_sel[i] = 0;
      m_inc[i] = 0;
    end
    m_inh = '1;
    m_ovf = '0;
    m_ie  = '0;
    m_irq = 0;
  endfunction

  function automatic void model_read(input bit acc, input bit [11:0] a,
                                     output bit hit, output bit [31:0] d);
    hit = 0;
    d   = 0;
    if (!acc) return;
    for (int i = 0; i < NC; i++) begin
      if (a == 12'h7C0 + 12'(i)) begin hit = 1; d = 32'(m_sel[i]); end
      if (a == 12'hB00 + 12'(i)) begin hit = 1; d = 32'(m_cnt[i] & LO_MASK); end
      if (a == 12'hB80 + 12'(i)) begin hit = 1; d = 32'(m_cnt[i] >> 32); end
    end
    if (a == 12'h320) begin hit = 1; d = 32'(m_inh); end
    if (a == 12'h7E0) begin hit = 1; d = 32'(m_ovf); end
    if (a == 12'h7E1) begin hit = 1; d = 32'(m_ie); end
  endfunction

  function automatic void model_advance(input bit acc, input bit [11:0] a, input bit [1:0] op,
                                        input bit [31:0] wd, input bit [NE-1:0] ev);
    bit          hit, wr;
    bit [31:0]   unused_d;
    bit [NC-1:0] ovf_new;
    bit          nxt_inc [NC];
    bit          nxt_irq;
    longint unsigned lo, hi;
    model_read(acc, a, hit, unused_d);
    wr      = hit && (op != OP_NONE);
    ovf_new = '0;
    nxt_irq = |(m_ovf & m_ie);
    for (int i = 0; i < NC; i++) begin
      nxt_inc[i] = (m_sel[i] < NE) ? ev[m_sel[i]] : 1'b0;
      if (m_inh[i]) nxt_inc[i] = 0;
    end
    for (int i = 0; i < NC; i++) begin
      bit wl, wh;
      wl = wr && (a == 12'hB00 + 12'(i));
      wh = wr && (a == 12'hB80 + 12'(i));
      if (wl || wh) begin
        lo = m_cnt[i] & LO_MASK;
        hi = m_cnt[i] >> 32;
        if (wl) lo = apply(op, lo, 64'(wd)) & LO_MASK;
        if (wh) hi = apply(op, hi, 64'(wd)) & HI_MASK;
        m_cnt[i] = (hi << 32) | lo;
      end else if (m_inc[i]) begin
        if (m_cnt[i] == CNT_MAX) begin
          ovf_new[i] = 1;
`ifdef HPM_SATURATE_EN
          m_cnt[i] = CNT_MAX;
`else
          m_cnt[i] = 0;
`endif
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
      if (wr && (a == 12'h7C0 + 12'(i))) m_sel[i] = 32'(apply(op, 64'(m_sel[i]), 64'(wd)) & 31);
    end
    if (wr && a == 12'h320) m_inh = NC'(apply(op, 64'(m_inh), 64'(wd)));
    if (wr && a == 12'h7E1) m_ie  = NC'(apply(op, 64'(m_ie), 64'(wd)));
    if (wr && a == 12'h7E0) m_ovf = NC'(apply(op, 64'(m_ovf), 64'(wd)));
    m_ovf = m_ovf | ovf_new;
    for (int i = 0; i < NC; i++) m_inc[i] = nxt_inc[i];
    m_irq = nxt_irq;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Called just after a rising edge: drive, check against model, advance one clock
  task automatic step(input bit acc, input bit [11:0] a, input bit [1:0] op,
                      input bit [31:0] wd, input bit [NE-1:0] ev);
    bit        hit;
    bit [31:0] rd;
    csr_access_i = acc;
    csr_addr_i   = a;
    csr_op_i     = op;
    csr_wdata_i  = wd;
    events_i     = ev;
    #1;
    model_read(acc, a, hit, rd);
    check_eq($sformatf("hit@%03h", a), 64'(csr_hit_o), 64'(hit));
    check_eq($sformatf("rdata@%03h", a), 64'(csr_rdata_o), 64'(rd));
    check_eq("irq", 64'(ovf_irq_o), 64'(m_irq));
    model_advance(acc, a, op, wd, ev);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 12'h000, OP_NONE, 0, '0);
  endtask

  // Read without advancing the clock; checked against fixed expectations
  task automatic peek(input string tag, input bit [11:0] a, input bit exp_hit,
                      input bit [31:0] exp_d);
    csr_access_i = 1;
    csr_addr_i   = a;
    csr_op_i     = OP_NONE;
    csr_wdata_i  = 0;
    events_i     = '0;
    #1;
    check_eq({tag, "_hit"}, 64'(csr_hit_o), 64'(exp_hit));
    check_eq(tag, 64'(csr_rdata_o), 64'(exp_d));
  endtask

  task automatic rand_step();
    bit [11:0]   a;
    bit [1:0]    op;
    bit [31:0]   wd;
    bit          acc;
    bit [NE-1:0] ev;
    case ($urandom_range(0, 9))
      0:       a = 12'h7C0 + 12'($urandom_range(0, 5));
      1:       a = 12'hB00 + 12'($urandom_range(0, 4));
      2:       a = 12'hB80 + 12'($urandom_range(0, 4));
      3:       a = 12'h320;
      4:       a = 12'h7E0;
      5:       a = 12'h7E1;
      6:       a = 12'($urandom);
      default: a = 12'hB00 + 12'($urandom_range(0, 3));
    endcase
    op  = 2'($urandom_range(0, 3));
    wd  = $urandom;
    if ($urandom_range(0, 3) == 0) wd = 32'hFFFF_FFFF;
    if (a[11:4] == 8'h7C && $urandom_range(0, 1) == 1) wd = 32'($urandom_range(0, 20));
    if (a == 12'h320 && $urandom_range(0, 1) == 1) op = OP_CLEAR;
    acc = ($urandom_range(0, 7) != 0);
    ev  = NE'($urandom);
    step(acc, a, op, wd, ev);
  endtask

  // ---------------- test sequence ----------------
  bit [31:0] exp_wrap;

  initial begin
`ifdef HPM_SATURATE_EN
    exp_wrap = 32'hFFFF_FFFF;
`else
    exp_wrap = 32'h0;
`endif
    rst_n        = 0;
    csr_access_i = 0;
    csr_addr_i   = 0;
    csr_wdata_i  = 0;
    csr_op_i     = 0;
    events_i     = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;

    // Reset state
    check_eq("rst_irq", 64'(ovf_irq_o), 64'h0);
    peek("rst_inhibit", 12'h320, 1, 32'hF);
    peek("rst_cnt0", 12'hB00, 1, 32'h0);
    idle(1);
    peek("rst_ovf", 12'h7E0, 1, 32'h0);
    peek("rst_evtsel0", 12'h7C0, 1, 32'h0);

    // Basic counting: select event 2, enable counter 0, three pulses
    step(1, 12'h7C0, OP_WRITE, 32'd2, '0);
    step(1, 12'h320, OP_CLEAR, 32'd1, '0);
    for (int k = 0; k < 3; k++) begin
      step(0, 12'h000, OP_NONE, 0, NE'(1 << 2));
      idle(1);
    end
    idle(1);
    peek("count3_lo", 12'hB00, 1, 32'd3);
    peek("count3_hi", 12'hB80, 1, 32'd0);

    // Wrap / saturate with interrupt
    step(1, 12'hB00, OP_WRITE, 32'hFFFF_FFFF, '0);
    step(1, 12'hB80, OP_WRITE, 32'hFFFF_FFFF, '0);
    step(1, 12'h7E1, OP_WRITE, 32'd1, '0);
    step(0, 12'h000, OP_NONE, 0, NE'(1 << 2));
    idle(1);
    peek("wrap_lo", 12'hB00, 1, exp_wrap);
    peek("wrap_hi", 12'hB80, 1, exp_wrap);
    peek("wrap_ovf", 12'h7E0, 1, 32'd1);
    check_eq("irq_lag", 64'(ovf_irq_o), 64'h0);
    idle(1);
    check_eq("irq_set", 64'(ovf_irq_o), 64'h1);

    // Software clear coincident with a new overflow keeps the bit
    step(1, 12'hB00, OP_WRITE, 32'hFFFF_FFFF, '0);
    step(1, 12'hB80, OP_WRITE, 32'hFFFF_FFFF, '0);
    step(0, 12'h000, OP_NONE, 0, NE'(1 << 2));
    step(1, 12'h7E0, OP_CLEAR, 32'd1, '0);
    peek("ovf_race", 12'h7E0, 1, 32'd1);
    step(1, 12'h7E0, OP_CLEAR, 32'd1, '0);
    peek("ovf_clr", 12'h7E0, 1, 32'd0);
    check_eq("irq_hold", 64'(ovf_irq_o), 64'h1);
    idle(1);
    check_eq("irq_drop", 64'(ovf_irq_o), 64'h0);

    // Write overrides a coincident increment
    step(0, 12'h000, OP_NONE, 0, NE'(1 << 2));
    step(1, 12'hB00, OP_WRITE, 32'h1234, '0);
    peek("wr_override", 12'hB00, 1, 32'h1234);

    // Out-of-range event select never counts; out-of-range counter index misses
    step(1, 12'h7C0, OP_WRITE, 32'd31, '0);
    step(1, 12'hB00, OP_WRITE, 32'd0, '0);
    step(1, 12'hB80, OP_WRITE, 32'd0, '0);
    for (int k = 0; k < 3; k++) step(0, 12'h000, OP_NONE, 0, '1);
    idle(2);
    peek("sel31_cnt", 12'hB00, 1, 32'd0);
    peek("b0f", 12'hB0F, 0, 32'd0);

    // Reset in the middle of counting
    step(1, 12'h320, OP_WRITE, 32'd0, '0);
    step(1, 12'h7C0, OP_WRITE, 32'd1, '0);
    for (int k = 0; k < 8; k++) step(0, 12'h000, OP_NONE, 0, NE'($urandom));
    rst_n = 0;
    model_reset();
    peek("mid_rst_inhibit", 12'h320, 1, 32'hF);
    check_eq("mid_rst_irq", 64'(ovf_irq_o), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1;
    peek("post_rst_inhibit", 12'h320, 1, 32'hF);
    peek("post_rst_cnt0", 12'hB00, 1, 32'd0);
    peek("post_rst_cnt1", 12'hB01, 1, 32'd0);
    idle(2);
    peek("post_rst_cnt0b", 12'hB00, 1, 32'd0);

    // Randomized traffic against the model
    for (int k = 0; k < 1500; k++) rand_step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
